// File: rtl/axis_cpu_loader.sv
// Command-stream loader for the CPU core: writes instruction/immediate/jump-offset
// memories from AXI-Stream packets, controls hold_in_rst and returns one status word per packet.
module axis_cpu_loader #(
    parameter int CODE_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                cmd_TDATA,
    input  logic                       cmd_TVALID,
    output logic                       cmd_TREADY,
    input  logic                       cmd_TLAST,
    output logic [31:0]                rsp_TDATA,
    output logic                       rsp_TVALID,
    input  logic                       rsp_TREADY,
    output logic [CODE_ADDR_WIDTH-1:0] inst_wr_addr,
    output logic [7:0]                 inst_wr_data,
    output logic                       inst_wr_en,
    output logic [CODE_ADDR_WIDTH-1:0] imm_wr_addr,
    output logic [31:0]                imm_wr_data,
    output logic                       imm_wr_en,
    output logic [CODE_ADDR_WIDTH-1:0] jmp_wr_addr,
    output logic [CODE_ADDR_WIDTH-1:0] jmp_wr_data,
    output logic                       jmp_wr_en,
    output logic                       hold_in_rst
);
    localparam int          AW    = CODE_ADDR_WIDTH;
    localparam logic [16:0] DEPTH = 17'(1) << AW;

    localparam logic [7:0] C_CODE  = 8'h01;
    localparam logic [7:0] C_IMM   = 8'h02;
    localparam logic [7:0] C_JMP   = 8'h03;
    localparam logic [7:0] C_START = 8'h10;
    localparam logic [7:0] C_HALT  = 8'h11;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_RESP} state_t;

    state_t          r_state;
    logic [7:0]      r_cmd;
    logic [15:0]     r_base;
    logic [15:0]     r_count;
    logic            r_err;
    logic            r_ready;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_data;
    logic [AW-1:0]   r_waddr;
    logic [31:0]     r_wdata;
    logic            r_inst_en;
    logic            r_imm_en;
    logic            r_jmp_en;
    logic            r_hold;

    logic            w_hs;
    logic [7:0]      w_hdr_cmd;
    logic [16:0]     w_addr17;
    logic            w_in_range;
    logic [15:0]     w_cnt_inc;
    logic            w_unused_rsvd;

    assign w_hs          = cmd_TVALID & r_ready;
    assign w_hdr_cmd     = cmd_TDATA[31:24];
    assign w_addr17      = {1'b0, r_base} + {1'b0, r_count};
    assign w_in_range    = (w_addr17 < DEPTH);
    assign w_cnt_inc     = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
    assign w_unused_rsvd = ^cmd_TDATA[23:16];

    function automatic logic [31:0] rsp_word(input logic [7:0] c, input logic e,
                                             input logic [15:0] n);
        return {c, e, 7'b0, n};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_base      <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_inst_en   <= 1'b0;
            r_imm_en    <= 1'b0;
            r_jmp_en    <= 1'b0;
            r_hold      <= 1'b1;
        end else begin
            r_inst_en <= 1'b0;
            r_imm_en  <= 1'b0;
            r_jmp_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_hs) begin
                        r_cmd   <= w_hdr_cmd;
                        r_base  <= cmd_TDATA[15:0];
                        r_count <= '0;
                        r_err   <= 1'b0;
                        case (w_hdr_cmd)
                            C_CODE, C_IMM, C_JMP: begin
                                r_hold <= 1'b1;
                                if (cmd_TLAST) begin
                                    r_state     <= S_RESP;
                                    r_ready     <= 1'b0;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_data  <= rsp_word(w_hdr_cmd, 1'b0, 16'd0);
                                end else begin
                                    r_state <= S_LOAD;
                                end
                            end
                            C_START, C_HALT: begin
                                r_hold <= (w_hdr_cmd == C_HALT);
                                if (cmd_TLAST) begin
                                    r_state     <= S_RESP;
                                    r_ready     <= 1'b0;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_data  <= rsp_word(w_hdr_cmd, 1'b0, 16'd0);
                                end else begin
                                    r_err   <= 1'b1;
                                    r_state <= S_DRAIN;
                                end
                            end
                            default: begin
                                r_err <= 1'b1;
                                if (cmd_TLAST) begin
                                    r_state     <= S_RESP;
                                    r_ready     <= 1'b0;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_data  <= rsp_word(w_hdr_cmd, 1'b1, 16'd0);
                                end else begin
                                    r_state <= S_DRAIN;
                                end
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_count <= w_cnt_inc;
                        // Out-of-range beats are still counted but never written.
                        if (w_in_range) begin
                            r_waddr   <= w_addr17[AW-1:0];
                            r_wdata   <= cmd_TDATA;
                            r_inst_en <= (r_cmd == C_CODE);
                            r_imm_en  <= (r_cmd == C_IMM);
                            r_jmp_en  <= (r_cmd == C_JMP);
                        end else begin
                            r_err <= 1'b1;
                        end
                        if (cmd_TLAST) begin
                            r_state     <= S_RESP;
                            r_ready     <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= rsp_word(r_cmd, r_err | ~w_in_range, w_cnt_inc);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_hs && cmd_TLAST) begin
                        r_state     <= S_RESP;
                        r_ready     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= rsp_word(r_cmd, r_err, r_count);
                    end
                end
                S_RESP: begin
                    if (rsp_TREADY) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        r_ready     <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_TREADY   = r_ready;
    assign rsp_TDATA    = r_rsp_data;
    assign rsp_TVALID   = r_rsp_valid;
    assign inst_wr_addr = r_waddr;
    assign inst_wr_data = r_wdata[7:0];
    assign inst_wr_en   = r_inst_en;
    assign imm_wr_addr  = r_waddr;
    assign imm_wr_data  = r_wdata;
    assign imm_wr_en    = r_imm_en;
    assign jmp_wr_addr  = r_waddr;
    assign jmp_wr_data  = r_wdata[AW-1:0];
    assign jmp_wr_en    = r_jmp_en;
    assign hold_in_rst  = r_hold;

endmodule

// File: doc/axis_cpu_loader.md
Name: axis_cpu_loader

Overview:
- Upstream programming stage for the CPU core.
- Consumes a 32-bit AXI-Stream of command packets and writes the CPU's instruction, immediate and jump-offset memories.
- Drives the core's hold_in_rst (keeps the CPU in reset while code is loaded), then returns one 32-bit status word per packet.

Parameters:
CODE_ADDR_WIDTH, 10, address width of instruction/immediate/jump-offset memories (depth 2^CODE_ADDR_WIDTH each; legal 1..16)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_TDATA  in  32  command stream data
cmd_TVALID  in  1  command stream valid
cmd_TREADY  out  1  command stream ready
cmd_TLAST  in  1  last beat of packet
rsp_TDATA  out  32  status word
rsp_TVALID  out  1  status valid
rsp_TREADY  in  1  status ready
inst_wr_addr  out  CODE_ADDR_WIDTH  instruction memory write address
inst_wr_data  out  8  instruction byte (payload bits [7:0])
inst_wr_en  out  1  instruction write strobe
imm_wr_addr  out  CODE_ADDR_WIDTH  immediate memory write address
imm_wr_data  out  32  immediate value
imm_wr_en  out  1  immediate write strobe
jmp_wr_addr  out  CODE_ADDR_WIDTH  jump-offset memory write address
jmp_wr_data  out  CODE_ADDR_WIDTH  jump offset (payload low bits)
jmp_wr_en  out  1  jump-offset write strobe
hold_in_rst  out  1  holds CPU core in reset when 1

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously forces: state IDLE, all *_wr_en=0, addresses/data=0, rsp_TVALID=0, rsp_TDATA=0, cmd_TREADY=0, hold_in_rst=1.
- Header word (first beat of a packet):
  - [31:24] cmd: 0x01 LOAD_CODE, 0x02 LOAD_IMM, 0x03 LOAD_JMP, 0x10 START, 0x11 HALT.
  - [23:16] reserved, ignored.
  - [15:0] base address.
- FSM states: IDLE, LOAD, DRAIN, RESP.
- IDLE:
  - cmd_TREADY=1.
  - On header handshake, latch cmd and base; clear count and err.
  - LOAD_*: set hold_in_rst=1 in the same edge. Go to LOAD; go straight to RESP if TLAST is set on the header (zero-length load).
  - START: hold_in_rst=0. HALT: hold_in_rst=1. Both go to RESP; if the header lacks TLAST, set err and go to DRAIN.
  - Unknown cmd: set err; go to RESP if TLAST, else DRAIN.
- LOAD:
  - cmd_TREADY=1. Each payload handshake targets address base+count.
  - If base+count < 2^CODE_ADDR_WIDTH (compute in 17 bits, no wrap), pulse the selected *_wr_en for exactly one cycle, on the cycle after the handshake, with registered addr/data.
  - Otherwise suppress the write and set err (sticky).
  - count increments per beat, saturating at 0xFFFF.
  - TLAST beat goes to RESP.
- DRAIN:
  - cmd_TREADY=1. Discard beats; no writes.
  - TLAST goes to RESP. count does not advance.
- RESP:
  - cmd_TREADY=0.
  - rsp_TDATA = {cmd[7:0], err, 7'b0, count[15:0]}, registered. rsp_TVALID=1 and held stable until rsp_TREADY.
  - After the response handshake go to IDLE.
- Latency:
  - Write strobe 1 cycle after the payload handshake.
  - rsp_TVALID asserts on the cycle after the TLAST handshake.
  - Full rate: one payload beat per cycle.
- hold_in_rst changes only on START/HALT/LOAD header acceptance or reset. It is not released at the end of a LOAD.
- TVALID low mid-packet: wait in the current state; no timeout.
- Back-to-back packets: the next header is accepted on the cycle after the response handshake.

Test Plan:
- Reset release, no traffic -> hold_in_rst=1, cmd_TREADY=1 one cycle after reset deasserts, no write strobes, rsp_TVALID=0.
- LOAD_CODE base 0x004, payload 0xAB,0xCD,0xEF (TLAST on 3rd) -> inst_wr_en pulses at addr 4,5,6 with data AB,CD,EF; rsp=0x01000003; hold_in_rst stays 1.
- LOAD_IMM base 0x3FE, 4 payload words, CODE_ADDR_WIDTH=10 -> writes at 0x3FE,0x3FF only; rsp=0x02800004 (err set).
- Unknown cmd 0x55 followed by 2 payload beats -> no writes, beats drained, rsp=0x55800000.
- START (header with TLAST) -> hold_in_rst falls on the accept edge, rsp=0x10000000. Hold rsp_TREADY=0 for 5 cycles: rsp_TDATA stable and cmd_TREADY=0 throughout.
- LOAD_JMP 2 beats with rst_n pulsed low after the first beat -> outputs reset immediately, hold_in_rst=1, no response. A following LOAD_JMP base 0, 1 beat -> rsp=0x03000001.
